// File: rtl/magcmp_pkg.sv
// Shared types and verdict encodings for the serial magnitude comparator.
// Verdict vectors are ordered {c2,c1,c0} = {lt,eq,gt}.
package magcmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;

endpackage

// File: rtl/mag_cmp2_slice.sv
// Combinational 2-bit unsigned comparator slice.
// Outputs are mutually exclusive: gt, eq, lt.
module mag_cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       c0,
  output logic       c1,
  output logic       c2
);

  assign c0 = (a > b);
  assign c1 = (a == b);
  assign c2 = (a < b);

endmodule

// File: rtl/serial_magnitude_cmp.sv
// Multi-cycle unsigned magnitude comparator, 2 bits per cycle MSB-first.
// One one-hot verdict per transaction over valid/ready handshakes.
module serial_magnitude_cmp
  import magcmp_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int N          = WIDTH / 2,
  localparam int CW         = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c0,
  output logic             c1,
  output logic             c2,
  output logic             busy,
  output logic [CW-1:0]    slices_used
);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic [2:0]       acc;
  logic [2:0]       verdict;

  logic          s_gt;
  logic          s_eq;
  logic          s_lt;
  logic [2:0]    slice_res;
  logic          slice_ne;
  logic [CW-1:0] cnt_next;
  logic          last;
  logic          decide;
  logic [2:0]    final_v;

  mag_cmp2_slice u_slice (
    .a  (sa[WIDTH-1 -: 2]),
    .b  (sb[WIDTH-1 -: 2]),
    .c0 (s_gt),
    .c1 (s_eq),
    .c2 (s_lt)
  );

  assign slice_res = {s_lt, s_eq, s_gt};
  assign slice_ne  = !s_eq;
  assign cnt_next  = cnt + 1'b1;
  assign last      = (cnt_next == CW'(N));
  assign decide    = (slice_ne && EARLY_EXIT) || last;
  // acc remembers the first non-equal slice when running all slices
  assign final_v   = (acc != CMP_EQ) ? acc : slice_res;

  assign {c2, c1, c0} = verdict;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      verdict     <= '0;
      slices_used <= '0;
      sa          <= '0;
      sb          <= '0;
      cnt         <= '0;
      acc         <= CMP_EQ;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= a;
            sb       <= b;
            cnt      <= '0;
            acc      <= CMP_EQ;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_next;
          if (decide) begin
            verdict     <= final_v;
            slices_used <= cnt_next;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            sa <= sa << 2;
            sb <= sb << 2;
            if (slice_ne && (acc == CMP_EQ))
              acc <= slice_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            verdict   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// Directed bench for serial_magnitude_cmp at WIDTH 8 and 4, both exit modes.
// Units: 0 = W8/early, 1 = W8/full, 2 = W4/early, 3 = W4/full.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) passed++; \
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp); \
  end

module tb_serial_magnitude_cmp;
  import magcmp_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       iv   [4];
  logic       ordy [4];
  logic       irdy [4];
  logic       ov   [4];
  logic       bsy  [4];
  logic [2:0] v    [4];
  logic [2:0] us8  [2];
  logic [1:0] us4  [2];

  int checks = 0;
  int passed = 0;

  serial_magnitude_cmp #(.WIDTH(8), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a8), .b(b8), .out_valid(ov[0]), .out_ready(ordy[0]),
    .c0(v[0][0]), .c1(v[0][1]), .c2(v[0][2]),
    .busy(bsy[0]), .slices_used(us8[0])
  );

  serial_magnitude_cmp #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a8), .b(b8), .out_valid(ov[1]), .out_ready(ordy[1]),
    .c0(v[1][0]), .c1(v[1][1]), .c2(v[1][2]),
    .busy(bsy[1]), .slices_used(us8[1])
  );

  serial_magnitude_cmp #(.WIDTH(4), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a8[3:0]), .b(b8[3:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .c0(v[2][0]), .c1(v[2][1]), .c2(v[2][2]),
    .busy(bsy[2]), .slices_used(us4[0])
  );

  serial_magnitude_cmp #(.WIDTH(4), .EARLY_EXIT(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .a(a8[3:0]), .b(b8[3:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .c0(v[3][0]), .c1(v[3][1]), .c2(v[3][2]),
    .busy(bsy[3]), .slices_used(us4[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i] === 1'b1) begin
          if (!$onehot(v[i]))
            $error("FAIL onehot u%0d: %b", i, v[i]);
        end else if (v[i] !== 3'b000) begin
          $error("FAIL idle_zero u%0d: %b", i, v[i]);
        end
      end
    end
  end

  function automatic int used_of(input int u);
    if (u < 2) return int'(us8[u]);
    return int'(us4[u-2]);
  endfunction

  task automatic xact(input int u, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] ev, input int elat, input int hold);
    int lat;
    logic [2:0] held;
    @(negedge clk);
    a8 = a;
    b8 = b;
    iv[u] = 1'b1;
    `CHK("in_ready_idle", irdy[u], 1'b1)
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    a8 = ~a;
    b8 = ~b;
    lat = 0;
    while (!ov[u] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!ov[u])
      $error("FAIL timeout: unit %0d no out_valid", u);
    else
      passed++;
    `CHK("latency", lat, elat)
    `CHK("verdict", v[u], ev)
    `CHK("slices_used", used_of(u), elat)
    held = v[u];
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) `CHK("held_verdict", v[u], held)
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    `CHK("out_valid_clear", ov[u], 1'b0)
    `CHK("verdict_clear", v[u], 3'b000)
  endtask

  initial begin
    logic [2:0] ev;
    logic [2:0] hv;
    int elat;
    int lat;
    a8 = '0;
    b8 = '0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    `CHK("rst_in_ready", irdy[0], 1'b1)
    `CHK("rst_out_valid", ov[0], 1'b0)
    `CHK("rst_verdict", v[0], 3'b000)
    `CHK("rst_busy", bsy[0], 1'b0)
    `CHK("rst_used", used_of(0), 0)

    xact(0, 8'hA5, 8'hA5, CMP_EQ, 4, 0);
    xact(0, 8'hC0, 8'h40, CMP_GT, 1, 0);
    xact(0, 8'h12, 8'h13, CMP_LT, 4, 2);
    xact(0, 8'h00, 8'hFF, CMP_LT, 1, 0);
    xact(0, 8'hFF, 8'hFE, CMP_GT, 4, 0);
    xact(1, 8'hC0, 8'h40, CMP_GT, 4, 0);
    xact(1, 8'h12, 8'h13, CMP_LT, 4, 0);
    xact(1, 8'hA5, 8'hA5, CMP_EQ, 4, 1);

    @(negedge clk);
    a8 = 8'h80;
    b8 = 8'h00;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    a8 = 8'h00;
    b8 = 8'hFF;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!ov[0])
      $error("FAIL stall_timeout: no out_valid");
    else
      passed++;
    `CHK("stall_latency", lat, 1)
    hv = v[0];
    `CHK("stall_verdict", hv, CMP_GT)
    repeat (5) begin
      @(posedge clk);
      #1;
      `CHK("stall_hold", v[0], hv)
      `CHK("stall_in_ready", irdy[0], 1'b0)
      `CHK("stall_out_valid", ov[0], 1'b1)
      `CHK("stall_used", used_of(0), 1)
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    `CHK("stall_release", irdy[0], 1'b1)
    `CHK("stall_busy", bsy[0], 1'b0)

    @(negedge clk);
    a8 = 8'hA5;
    b8 = 8'hA5;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    `CHK("abort_in_ready", irdy[0], 1'b1)
    `CHK("abort_out_valid", ov[0], 1'b0)
    `CHK("abort_verdict", v[0], 3'b000)
    repeat (4) begin
      @(posedge clk);
      #1;
      `CHK("abort_quiet", ov[0], 1'b0)
    end
    xact(0, 8'h01, 8'h00, CMP_GT, 4, 0);

    for (int u = 2; u < 4; u++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          ev = (x > y) ? CMP_GT : ((x == y) ? CMP_EQ : CMP_LT);
          if (u == 2 && (x / 4) != (y / 4)) elat = 1;
          else elat = 2;
          xact(u, 8'(x), 8'(y), ev, elat, int'($urandom_range(0, 2)));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
